// File: rtl/demo_sum_pkg.sv
// rtl/demo_sum_pkg.sv - shared constants and control decode for the demo_sum accumulator tile
package demo_sum_pkg;

  localparam int ACC_W = 16;

  // Control bit positions within uio_in
  localparam int CTL_LOAD = 4;
  localparam int CTL_ADD  = 5;
  localparam int CTL_SEL  = 6;
  localparam int CTL_CLR  = 7;

  // Flag bit positions within uio_out
  localparam int FLG_OVF   = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_VALID = 2;
  localparam int FLG_PAR   = 3;

  // Low nibble of the bidir pins drives flags, high nibble receives controls
  localparam logic [7:0] UIO_OE_MASK = 8'h0F;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_ADD  = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  // Resolve simultaneous controls: CLR beats LOAD beats ADD
  function automatic op_e decode_op(input logic [7:0] ctl);
    if (ctl[CTL_CLR])
      return OP_CLR;
    else if (ctl[CTL_LOAD])
      return OP_LOAD;
    else if (ctl[CTL_ADD])
      return OP_ADD;
    else
      return OP_HOLD;
  endfunction

endpackage

// File: rtl/demo_sum_flags.sv
// rtl/demo_sum_flags.sv - combinational zero and parity flags derived from the accumulator
module demo_sum_flags
  import demo_sum_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  output logic             zero,
  output logic             par
);

  // Both flags follow the registered accumulator with no added delay
  always_comb begin
    zero = (acc == '0);
    par  = ^acc;
  end

endmodule

// File: rtl/demo_sum.sv
// rtl/demo_sum.sv - 16-bit running-sum accumulator tile for 8-bit operands
module demo_sum
  import demo_sum_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             valid;
  logic             zero;
  logic             par;
  logic [ACC_W:0]   sum;
  op_e              op;

  // uio_in[3:0] are output-direction pins on the tile and carry nothing for us
  logic unused_low_nibble;
  assign unused_low_nibble = ^uio_in[3:0];

  assign op  = decode_op(uio_in);
  // One extra bit keeps the carry out of the 16-bit add for the sticky overflow
  assign sum = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, ui_in};

  // Accumulator and status state; rst_n is active-high despite its pin name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc   <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else if (ena) begin
      case (op)
        OP_CLR: begin
          acc   <= '0;
          ovf   <= 1'b0;
          valid <= 1'b0;
        end
        OP_LOAD: begin
          acc   <= {{(ACC_W - 8){1'b0}}, ui_in};
          ovf   <= 1'b0;
          valid <= 1'b1;
        end
        OP_ADD: begin
          acc   <= sum[ACC_W-1:0];
          ovf   <= ovf | sum[ACC_W];
          valid <= 1'b1;
        end
        default: begin
          acc   <= acc;
          ovf   <= ovf;
          valid <= valid;
        end
      endcase
    end
  end

  demo_sum_flags u_flags (
    .acc  (acc),
    .zero (zero),
    .par  (par)
  );

  // Byte select and flag packing onto the tile pins
  always_comb begin
    uo_out             = uio_in[CTL_SEL] ? acc[ACC_W-1:8] : acc[7:0];
    uio_out            = 8'h00;
    uio_out[FLG_OVF]   = ovf;
    uio_out[FLG_ZERO]  = zero;
    uio_out[FLG_VALID] = valid;
    uio_out[FLG_PAR]   = par;
    uio_oe             = UIO_OE_MASK;
  end

endmodule

// File: tb/tb_demo_sum.sv
// tb/tb_demo_sum.sv - directed self-checking bench for demo_sum
module tb_demo_sum;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int errors;

  localparam logic [7:0] C_LOAD = 8'h10;
  localparam logic [7:0] C_ADD  = 8'h20;
  localparam logic [7:0] C_SEL  = 8'h40;
  localparam logic [7:0] C_CLR  = 8'h80;

  demo_sum dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Apply controls/operand, take one rising edge, settle 1 time unit past it
  task automatic step(input logic [7:0] ctl, input logic [7:0] d);
    uio_in = ctl;
    ui_in  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'hA5;
    uio_in = C_LOAD | C_ADD;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: controls present but ignored while held in reset
    uio_in = 8'h00;
    #1;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h02);
    check("rst_uio_oe", uio_oe, 8'h0F);
    rst_n = 1'b0;

    // LOAD 0x34, ADD 0x12 -> 0x0046 (three ones, PAR=1); junk low nibble ignored
    step(C_LOAD | 8'h0F, 8'h34);
    check("load_34", uo_out, 8'h34);
    step(C_ADD | 8'h05, 8'h12);
    check("add_lo", uo_out, 8'h46);
    check("add_flags", uio_out, 8'h0C);
    uio_in = C_SEL;
    #1;
    check("add_hi", uo_out, 8'h00);
    uio_in = 8'h00;
    #1;

    // Hold with no controls
    step(8'h00, 8'hEE);
    check("hold_lo", uo_out, 8'h46);

    // LOAD 0xFF then 255 ADDs of 0xFF -> 0xFF * 256 = 0xFF00
    step(C_LOAD, 8'hFF);
    for (int i = 0; i < 255; i++) step(C_ADD, 8'hFF);
    check("big_lo", uo_out, 8'h00);
    uio_in = C_SEL;
    #1;
    check("big_hi", uo_out, 8'hFF);
    check("big_flags", uio_out, 8'h04);
    // 0xFF00 + 0xFF -> 0xFFFF, no carry, 16 ones so PAR=0
    step(C_ADD | C_SEL, 8'hFF);
    check("ffff_hi", uo_out, 8'hFF);
    check("ffff_flags", uio_out, 8'h04);
    // Wrap: 0xFFFF + 1 -> 0x0000, OVF=1, ZERO=1, VALID=1
    step(C_ADD, 8'h01);
    check("wrap_lo", uo_out, 8'h00);
    check("wrap_flags", uio_out, 8'h07);
    // Sticky OVF survives a non-carrying ADD (acc=0x0003, PAR=0)
    step(C_ADD, 8'h03);
    check("sticky_lo", uo_out, 8'h03);
    check("sticky_flags", uio_out, 8'h05);

    // CLR wins over LOAD and ADD
    step(C_CLR | C_LOAD | C_ADD, 8'h55);
    check("clr_lo", uo_out, 8'h00);
    check("clr_flags", uio_out, 8'h02);
    // LOAD wins over ADD: 0x0055 has four ones, PAR=0
    step(C_LOAD | C_ADD, 8'h55);
    check("ldadd_lo", uo_out, 8'h55);
    check("ldadd_flags", uio_out, 8'h04);

    // Freeze with ena=0 for 5 cycles
    ena = 1'b0;
    for (int i = 0; i < 5; i++) step(C_ADD, 8'h10);
    check("frz_lo", uo_out, 8'h55);
    check("frz_flags", uio_out, 8'h04);
    ena = 1'b1;
    step(C_ADD, 8'h10);
    check("unfrz_lo", uo_out, 8'h65);
    check("unfrz_flags", uio_out, 8'h04);

    // Async reset between edges clears outputs immediately
    uio_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_lo", uo_out, 8'h00);
    check("arst_flags", uio_out, 8'h02);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step(8'h00, 8'h00);
    check("post_rst_lo", uo_out, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
